imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader upstream of the single-cycle core's instruction memory.
- Receives a framed byte stream (header, packed instruction words, checksum) over a valid/ready handshake.
- Assembles DATA_WIDTH-bit instructions and writes them sequentially into instruction memory from address 0.
- Holds the core stopped via cpu_run until a frame loads cleanly, then releases it.

Parameters:
DATA_WIDTH, 20, instruction width; BYTES = ceil(DATA_WIDTH/8) = 3 bytes per word
ADDRESS_WIDTH, 8, instruction memory address width
MEM_SIZE, 256, instruction memory depth in words

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a new load frame
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
imem_we  output  1  instruction memory write strobe
imem_addr  output  ADDRESS_WIDTH  write address
imem_wdata  output  DATA_WIDTH  write data
loaded_words  output  ADDRESS_WIDTH+1  words written in the current frame
busy  output  1  frame in progress
done  output  1  frame loaded successfully
error  output  1  frame failed
err_code  output  2  01 = nonzero pad bits, 10 = checksum mismatch
cpu_run  output  1  high only in DONE; gates the core's reset/run

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; word counter, byte index and checksum cleared. Instruction memory contents are not cleared.
- Byte transfer: a byte is accepted only on a clk edge where in_valid=1 and in_ready=1. in_ready is registered-state driven, never combinationally dependent on in_valid.
- Frame layout: header byte N, then N words of BYTES bytes each (little-endian), then one checksum byte. N=0 means MEM_SIZE words. N greater than MEM_SIZE is clamped to MEM_SIZE.

FSM states:
- IDLE: in_ready=0. start moves to HDR; busy=1 from the next cycle.
- HDR: in_ready=1. On accept, latch N, set checksum = byte, clear the word counter, go to B0.
- Bk (k = 0..BYTES-1): in_ready=1. On accept, place the byte at bits [8k+7:8k] of the assembly register, XOR it into the checksum, advance.
  - Bits of the final byte beyond DATA_WIDTH (bits 23:20 at default) must be 0; otherwise go to ERR with err_code=01 and perform no write.
- WRITE: exactly one cycle. in_ready=0, imem_we=1, imem_addr = word counter, imem_wdata = assembled word.
  - Next edge: counter +1 and loaded_words updated.
  - If counter == N go to CSUM, else go to B0.
- CSUM: in_ready=1. On accept, compare the byte to the running XOR. Match goes to DONE; mismatch goes to ERR with err_code=10.
- DONE: done=1, cpu_run=1, busy=0, in_ready=0.
- ERR: error=1, cpu_run=0, busy=0, in_ready=0.
- From DONE or ERR, start returns to HDR: done/error/err_code/cpu_run clear on the next edge and loaded_words resets to 0.

Timing and boundaries:
- Throughput: BYTES+1 cycles per word minimum; the stream may stall any number of cycles in any accepting state.
- start is ignored in HDR, Bk, WRITE and CSUM.
- The address never exceeds MEM_SIZE-1; the counter does not wrap within a frame.
- imem_addr and imem_wdata hold their last values outside WRITE. imem_we is 0 outside WRITE.
- Reset mid-frame aborts immediately. Already-written words remain in memory and cpu_run stays 0.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: the CSUM state and checksum comparison exist exactly as described above.
- Undefined: no checksum byte is expected; WRITE of word N goes directly to DONE; err_code 10 is never produced; the checksum register is not built.

Test Plan:
- Nominal, checksum enabled: start, then bytes 02, 13,00,00, FF,FF,0F, checksum 02^13^FF^FF^0F = 1E.
  - Writes addr0=0x00013 and addr1=0xFFFFF, one imem_we cycle each.
  - Then done=1, cpu_run=1, loaded_words=2.
- Bad pad: bytes 01, 00,00,10 -> ERR, err_code=01, imem_we never asserted, cpu_run=0.
- Bad checksum: bytes 01, 05,00,00, checksum 00 (expected 04) -> addr0 written with 0x00005, then ERR, err_code=10.
- Stalls: same stream as Nominal with in_valid low for 3 cycles between every byte -> identical writes and completion; no byte accepted while in_valid=0.
- Full load: N=00 with 256 words of value = index -> addr255=0x000FF written last, loaded_words=256, done=1.
- Reset and restart: rst low after 2 of 4 words -> all outputs 0 immediately. A fresh frame after reset release loads correctly. start pulsed in DONE clears cpu_run on the next cycle.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: stream and instruction-memory write bus of the boot loader.
//
//   start      host -> loader  one-cycle pulse, begins a new load frame
//   in_data    host -> loader  stream byte
//   in_valid   host -> loader  in_data valid
//   in_ready   loader -> host  loader accepts in_data this cycle
//   imem_we    loader -> imem  write strobe (one cycle per word)
//   imem_addr  loader -> imem  write address
//   imem_wdata loader -> imem  write data
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1. in_ready depends only on loader state, never on in_valid, and
// the host may hold in_valid low for any number of cycles between bytes.
//
// Modports: slave = loader side, master = host / memory side.
interface imem_loader_if #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8
) ();
  logic                     start;
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     imem_we;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_wdata;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the core's instruction
// memory. Consumes a framed byte stream
//   header N | N words of BYTES little-endian bytes | checksum byte
// writes each assembled word to consecutive addresses from 0, and raises
// cpu_run only once a frame has loaded cleanly.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   bus          imem_loader_if.slave (start, byte stream, imem write bus)
//   loaded_words words written in the current frame
//   busy         frame in progress
//   done         frame loaded successfully
//   error        frame failed
//   err_code     01 = nonzero pad bits, 10 = checksum mismatch
//   cpu_run      high only in DONE
//   state_dbg    current FSM state encoding, for observation only
//
// Build option IMEM_LOADER_CHECKSUM_EN: when defined, a trailing checksum
// byte (XOR of header and all data bytes) is expected and checked. When
// undefined, the write of the last word completes the frame directly and no
// checksum register exists.
//
// Header N = 0 means MEM_SIZE words; N > MEM_SIZE is clamped to MEM_SIZE.
module imem_loader #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  imem_loader_if.slave           bus,
  output logic [ADDRESS_WIDTH:0] loaded_words,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic                   cpu_run,
  output logic [2:0]             state_dbg
);

  localparam int BYTES     = (DATA_WIDTH + 7) / 8;
  localparam int IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W     = ADDRESS_WIDTH + 1;
  localparam int LAST_BITS = DATA_WIDTH - 8 * (BYTES - 1);
  // Bits of the final byte that lie above DATA_WIDTH and must be zero.
  localparam logic [7:0] PAD_MASK = 8'hFF << LAST_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_BYTE, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         n_words;
  logic [CNT_W-1:0]         word_cnt;
  logic [CNT_W-1:0]         cnt_inc;
  logic [CNT_W-1:0]         hdr_n;
  logic [IDX_W-1:0]         byte_idx;
  logic [8*(BYTES-1)-1:0]   asm_reg;     // bytes 0..BYTES-2 of the word
  logic [DATA_WIDTH-1:0]    word_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     in_ready_c;
  logic                     accept;
  logic                     last_byte;
  logic                     pad_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]               csum;
`endif

  assign accept    = bus.in_valid & in_ready_c;
  assign last_byte = (byte_idx == IDX_W'(BYTES - 1));
  assign pad_bad   = |(bus.in_data & PAD_MASK);
  assign cnt_inc   = word_cnt + CNT_W'(1);
  // The final byte goes straight into the write data, so the word is ready
  // for the WRITE cycle that immediately follows its acceptance.
  assign word_nxt  = DATA_WIDTH'({bus.in_data, asm_reg});

  always_comb begin
    if (bus.in_data == 8'd0 || int'(bus.in_data) > MEM_SIZE)
      hdr_n = CNT_W'(MEM_SIZE);
    else
      hdr_n = CNT_W'(bus.in_data);
  end

  always_comb begin
    state_nxt    = state;
    in_ready_c   = 1'b0;
    bus.imem_we  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    cpu_run      = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_HDR;
      S_HDR: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = S_BYTE;
      end
      S_BYTE: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        if (accept && last_byte) state_nxt = pad_bad ? S_ERR : S_WRITE;
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        busy        = 1'b1;
        if (cnt_inc == n_words)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        else
          state_nxt = S_BYTE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
        if (bus.start) state_nxt = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
        if (bus.start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words  <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      asm_reg  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_code <= 2'b00;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      case (state)
        S_HDR: if (accept) begin
          n_words  <= hdr_n;
          word_cnt <= '0;
          byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum     <= bus.in_data;
`endif
        end
        S_BYTE: if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ bus.in_data;
`endif
          if (last_byte) begin
            byte_idx <= '0;
            if (pad_bad) begin
              err_code <= 2'b01;
            end else begin
              addr_q  <= word_cnt[ADDRESS_WIDTH-1:0];
              wdata_q <= word_nxt;
            end
          end else begin
            for (int k = 0; k < BYTES - 1; k++)
              if (byte_idx == IDX_W'(k)) asm_reg[8*k +: 8] <= bus.in_data;
            byte_idx <= byte_idx + IDX_W'(1);
          end
        end
        S_WRITE: word_cnt <= cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: if (accept && bus.in_data != csum) err_code <= 2'b10;
`endif
        S_DONE, S_ERR: if (bus.start) begin
          word_cnt <= '0;
          err_code <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign loaded_words   = word_cnt;
  assign state_dbg      = state;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed frames against a byte-level frame
// model; writes are checked through an expected queue of {addr, data}.
module tb_imem_loader;

  localparam int DW = 20;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic [AW:0]   loaded_words;
  logic          busy, done, error, cpu_run;
  logic [1:0]    err_code;
  logic [2:0]    state_dbg;

  imem_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  imem_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .loaded_words (loaded_words),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .cpu_run      (cpu_run),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  logic [DW+AW-1:0] exp_q[$];
  logic [7:0]       frame_q[$];
  int exp_words, exp_code, exp_done, n_consume;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk)
    if (rst && bus.in_valid && bus.in_ready) acc_cnt++;

  always @(negedge clk) begin
    if (rst && bus.imem_we) begin
      check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        check("imem_write", 32'({bus.imem_addr, bus.imem_wdata}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- reference model ----------------
  // Walks frame_q as the frame rules describe and derives the writes, the
  // outcome and how many bytes the loader will take before it stops.
  task automatic predict();
    int n, pos, w;
    logic [7:0] x, b0, b1, b2;
    exp_q.delete();
    n = (frame_q[0] == 8'd0) ? 256 : int'(frame_q[0]);
    if (n > 256) n = 256;
    x = frame_q[0];
    pos = 1;
    exp_words = 0;
    exp_code = 0;
    exp_done = 0;
    for (int i = 0; i < n; i++) begin
      b0 = frame_q[pos];
      b1 = frame_q[pos+1];
      b2 = frame_q[pos+2];
      pos += 3;
      if (b2 >= 8'd16) begin
        exp_code = 1;
        break;
      end
      w = int'(b0) + 256 * int'(b1) + 65536 * int'(b2);
      exp_q.push_back({8'(i), 20'(w)});
      x = x ^ b0 ^ b1 ^ b2;
      exp_words++;
    end
    if (exp_code == 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (frame_q[pos] != x) exp_code = 2;
      else exp_done = 1;
      pos++;
`else
      exp_done = 1;
`endif
    end
    n_consume = pos;
  endtask

  // ---------------- drivers ----------------
  // Entered and left just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    bus.in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input int stall_min, input int stall_max);
    int acc0, t;
    predict();
    acc0 = acc_cnt;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("cpu_run_after_start", 32'(cpu_run), 32'd0);
    check("done_after_start", 32'(done), 32'd0);
    check("words_after_start", 32'(loaded_words), 32'd0);
    for (int k = 0; k < n_consume; k++)
      send_byte(frame_q[k], int'($urandom_range(stall_min, stall_max)));
    t = 0;
    while (!(done || error) && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_done == 0));
    check("err_code", 32'(err_code), 32'(exp_code));
    check("cpu_run", 32'(cpu_run), 32'(exp_done));
    check("loaded_words", 32'(loaded_words), 32'(exp_words));
    check("busy_end", 32'(busy), 32'd0);
    check("in_ready_end", 32'(bus.in_ready), 32'd0);
    check("bytes_accepted", 32'(acc_cnt - acc0), 32'(n_consume));
    check("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic build_random();
    int n;
    logic [7:0]  x, b2;
    logic [19:0] w;
    frame_q.delete();
    n = int'($urandom_range(1, 12));
    frame_q.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < n; i++) begin
      w  = 20'($urandom);
      b2 = {4'h0, w[19:16]};
      if ($urandom_range(0, 9) == 0) b2[7:4] = 4'($urandom_range(1, 15));
      frame_q.push_back(w[7:0]);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(b2);
      x = x ^ w[7:0] ^ w[15:8] ^ b2;
    end
    if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_loaded_words"}, 32'(loaded_words), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] x;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // nominal two-word frame
    frame_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h1E};
    run_frame(0, 0);

    // nonzero pad bits in the first word
    frame_q = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h11};
    run_frame(0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum mismatch after one good word
    frame_q = '{8'h01, 8'h05, 8'h00, 8'h00, 8'h00};
    run_frame(0, 0);
`endif

    // nominal frame with 3 idle cycles before every byte
    frame_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h1E};
    run_frame(3, 3);

    // full 256-word load, word value = index
    frame_q.delete();
    frame_q.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < 256; i++) begin
      frame_q.push_back(8'(i));
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
      x = x ^ 8'(i);
    end
    frame_q.push_back(x);
    run_frame(0, 0);

    // random frames with random stalls
    for (int r = 0; r < 8; r++) begin
      build_random();
      run_frame(0, 3);
    end

    // reset after 2 of 4 words
    frame_q = '{8'h04, 8'h11, 8'h00, 8'h00, 8'h22, 8'h33, 8'h04};
    exp_q.delete();
    exp_q.push_back({8'd0, 20'h00011});
    exp_q.push_back({8'd1, 20'h43322});
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(frame_q[k], 0);
    @(negedge clk);
    check("midframe_writes_left", 32'(exp_q.size()), 32'd0);
    #2 rst = 1'b0;
    #1 check_all_zero("midframe_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // fresh frame after reset release
    frame_q = '{8'h02, 8'h13, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h1E};
    run_frame(0, 1);

    // start pulsed in DONE: next cycle status clears
    pulse_start();
    check("restart_cpu_run", 32'(cpu_run), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_words", 32'(loaded_words), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
